// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - operand sequencer and result capture stage feeding mult_accum
module mac_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_a,
    input  logic [ADDR_WIDTH-1:0] i_base_b,
    input  logic [CNT_WIDTH-1:0]  i_num_taps,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_addr_a,
    output logic [ADDR_WIDTH-1:0] o_addr_b,
    input  logic [DATA_WIDTH-1:0] i_rdata_a,
    input  logic [DATA_WIDTH-1:0] i_rdata_b,
    output logic [1:0]            o_mac_control,
    output logic [DATA_WIDTH-1:0] o_mac_data_a,
    output logic [DATA_WIDTH-1:0] o_mac_data_b,
    input  logic [DATA_WIDTH-1:0] i_acc_in,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_result_valid,
    input  logic                  i_result_ready,
    output logic                  o_busy
);
    localparam logic [1:0] C_HOLD  = 2'b00;
    localparam logic [1:0] C_CLEAR = 2'b01;
    localparam logic [1:0] C_LOAD  = 2'b10;
    localparam logic [1:0] C_ACCUM = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_ZERO, S_OUT} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base_a, r_base_b;
    logic [CNT_WIDTH-1:0]  r_num, r_k;
    logic                  r_rd_v, r_rd_first, r_acc_v;
    logic [1:0]            r_mac_control;
    logic [DATA_WIDTH-1:0] r_mac_data_a, r_mac_data_b, r_result;

    logic w_last_read, w_mac_v, w_drain_done, w_zero_done, w_accept;

    assign w_last_read  = (r_k == r_num - CNT_WIDTH'(1));
    assign w_mac_v      = r_mac_control[1];
    // Last product has passed the accumulator register once only r_acc_v remains set.
    assign w_drain_done = r_acc_v && !w_mac_v && !r_rd_v;
    assign w_zero_done  = (r_k != '0);
    assign w_accept     = (r_state == S_IDLE) && i_start;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = (i_num_taps != '0) ? S_FETCH : S_ZERO;
            S_FETCH: if (w_last_read) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_next = S_OUT;
            S_ZERO:  if (w_zero_done) w_next = S_OUT;
            S_OUT:   if (i_result_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_rd_en        = (r_state == S_FETCH);
        o_addr_a       = o_rd_en ? r_base_a + ADDR_WIDTH'(r_k) : '0;
        o_addr_b       = o_rd_en ? r_base_b + ADDR_WIDTH'(r_k) : '0;
        o_busy         = (r_state != S_IDLE);
        o_result_valid = (r_state == S_OUT);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_base_a      <= '0;
            r_base_b      <= '0;
            r_num         <= '0;
            r_k           <= '0;
            r_rd_v        <= 1'b0;
            r_rd_first    <= 1'b0;
            r_acc_v       <= 1'b0;
            r_mac_control <= C_HOLD;
            r_mac_data_a  <= '0;
            r_mac_data_b  <= '0;
            r_result      <= '0;
        end else begin
            if (w_accept) begin
                r_base_a <= i_base_a;
                r_base_b <= i_base_b;
                r_num    <= i_num_taps;
                r_k      <= '0;
            end else if (r_state == S_FETCH || r_state == S_ZERO) begin
                r_k <= r_k + CNT_WIDTH'(1);
            end
            r_rd_v     <= (r_state == S_FETCH);
            r_rd_first <= (r_state == S_FETCH) && (r_k == '0);
            r_acc_v    <= w_mac_v;
            if (r_rd_v)
                r_mac_control <= r_rd_first ? C_LOAD : C_ACCUM;
            else if (w_accept && i_num_taps == '0)
                r_mac_control <= C_CLEAR;
            else
                r_mac_control <= C_HOLD;
            if (r_rd_v) begin
                r_mac_data_a <= i_rdata_a;
                r_mac_data_b <= i_rdata_b;
            end
            if ((r_state == S_DRAIN && w_drain_done) || (r_state == S_ZERO && w_zero_done))
                r_result <= i_acc_in;
        end
    end

    assign o_mac_control = r_mac_control;
    assign o_mac_data_a  = r_mac_data_a;
    assign o_mac_data_b  = r_mac_data_b;
    assign o_result      = r_result;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed vector bench for mac_sequencer with RAM and mult_accum models
module tb_mac_sequencer;
    localparam int DW = 16;
    localparam int AW = 9;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_a = '0, base_b = '0;
    logic [CW-1:0] num_taps = '0;
    logic          rd_en;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] rdata_a = '0, rdata_b = '0;
    logic [1:0]    mac_control;
    logic [DW-1:0] mac_data_a, mac_data_b;
    logic [DW-1:0] acc = '0;
    logic [DW-1:0] result;
    logic          result_valid;
    logic          result_ready = 1'b0;
    logic          busy;

    logic [DW-1:0] ram_a [0:511];
    logic [DW-1:0] ram_b [0:511];

    int total = 0;
    int bad   = 0;

    mac_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start),
        .i_base_a(base_a), .i_base_b(base_b), .i_num_taps(num_taps),
        .o_rd_en(rd_en), .o_addr_a(addr_a), .o_addr_b(addr_b),
        .i_rdata_a(rdata_a), .i_rdata_b(rdata_b),
        .o_mac_control(mac_control), .o_mac_data_a(mac_data_a), .o_mac_data_b(mac_data_b),
        .i_acc_in(acc), .o_result(result), .o_result_valid(result_valid),
        .i_result_ready(result_ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            rdata_a <= ram_a[addr_a];
            rdata_b <= ram_b[addr_b];
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else case (mac_control)
            2'b01:   acc <= '0;
            2'b10:   acc <= DW'(mac_data_a * mac_data_b);
            2'b11:   acc <= DW'(acc + mac_data_a * mac_data_b);
            default: acc <= acc;
        endcase
    end

    typedef struct {
        logic [AW-1:0] ba;
        logic [AW-1:0] bb;
        logic [CW-1:0] n;
        logic [DW-1:0] exp;
        bit            early_rdy;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int hold, input string tag);
        int            n;
        int            vc;
        logic [1:0]    exp_ctl;
        logic [AW-1:0] idx;
        logic [AW-1:0] idx_b;
        n  = int'(v.n);
        vc = (n == 0) ? 3 : n + 4;
        base_a = v.ba; base_b = v.bb; num_taps = v.n;
        result_ready = v.early_rdy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= vc; c++) begin
            chk({tag, "/rd_en"}, 32'(rd_en), 32'(n != 0 && c <= n));
            if (n != 0 && c <= n) begin
                idx   = v.ba + AW'(c - 1);
                idx_b = v.bb + AW'(c - 1);
                chk({tag, "/addr_a"}, 32'(addr_a), 32'(idx));
                chk({tag, "/addr_b"}, 32'(addr_b), 32'(idx_b));
            end
            if (n == 0)                    exp_ctl = (c == 1) ? 2'b01 : 2'b00;
            else if (c >= 3 && c <= n + 2) exp_ctl = (c == 3) ? 2'b10 : 2'b11;
            else                           exp_ctl = 2'b00;
            chk({tag, "/mac_control"}, 32'(mac_control), 32'(exp_ctl));
            if (exp_ctl[1]) begin
                idx   = v.ba + AW'(c - 3);
                idx_b = v.bb + AW'(c - 3);
                chk({tag, "/mac_data_a"}, 32'(mac_data_a), 32'(ram_a[idx]));
                chk({tag, "/mac_data_b"}, 32'(mac_data_b), 32'(ram_b[idx_b]));
            end
            chk({tag, "/result_valid"}, 32'(result_valid), 32'(c == vc));
            chk({tag, "/busy"}, 32'(busy), 32'd1);
            if (c < vc) @(negedge clk);
        end
        chk({tag, "/result"}, 32'(result), 32'(v.exp));
        if (hold > 0) begin
            result_ready = 1'b0;
            start = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk({tag, "/hold_valid"}, 32'(result_valid), 32'd1);
                chk({tag, "/hold_busy"}, 32'(busy), 32'd1);
                chk({tag, "/hold_rd_en"}, 32'(rd_en), 32'd0);
                chk({tag, "/hold_result"}, 32'(result), 32'(v.exp));
            end
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        start = 1'b0;
        chk({tag, "/exit_valid"}, 32'(result_valid), 32'd0);
        chk({tag, "/exit_busy"}, 32'(busy), 32'd0);
        chk({tag, "/exit_rd_en"}, 32'(rd_en), 32'd0);
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < 512; i++) begin
            ram_a[i] = '0;
            ram_b[i] = '0;
        end
        ram_a[9'h010] = 1; ram_a[9'h011] = 2; ram_a[9'h012] = 3; ram_a[9'h013] = 4;
        ram_b[9'h020] = 5; ram_b[9'h021] = 6; ram_b[9'h022] = 7; ram_b[9'h023] = 8;
        ram_a[9'h1FE] = 2; ram_a[9'h1FF] = 3; ram_a[9'h000] = 4;
        ram_b[9'h040] = 10; ram_b[9'h041] = 20; ram_b[9'h042] = 30;
        ram_a[9'h100] = 7; ram_b[9'h1FF] = 9;
        for (int i = 0; i < 5; i++) begin
            ram_a[9'h080 + i] = 1;
            ram_b[9'h090 + i] = DW'(i + 1);
        end

        vecs[0] = '{ba: 9'h010, bb: 9'h020, n: 6'd4, exp: 16'd70,  early_rdy: 1'b0};
        vecs[1] = '{ba: 9'h1FE, bb: 9'h040, n: 6'd3, exp: 16'd200, early_rdy: 1'b0};
        vecs[2] = '{ba: 9'h000, bb: 9'h000, n: 6'd0, exp: 16'd0,   early_rdy: 1'b0};
        vecs[3] = '{ba: 9'h100, bb: 9'h1FF, n: 6'd1, exp: 16'd63,  early_rdy: 1'b0};
        vecs[4] = '{ba: 9'h080, bb: 9'h090, n: 6'd5, exp: 16'd15,  early_rdy: 1'b1};

        @(negedge clk);
        @(negedge clk);
        chk("reset/rd_en", 32'(rd_en), 32'd0);
        chk("reset/mac_control", 32'(mac_control), 32'd0);
        chk("reset/result", 32'(result), 32'd0);
        chk("reset/result_valid", 32'(result_valid), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_job(vecs[i], 0, $sformatf("vec%0d", i));

        run_job(vecs[3], 10, "hold");

        rv = '{ba: 9'h100, bb: 9'h100, n: 6'd8, exp: 16'd0, early_rdy: 1'b0};
        base_a = rv.ba; base_b = rv.bb; num_taps = rv.n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset/rd_en", 32'(rd_en), 32'd0);
        chk("midreset/addr_a", 32'(addr_a), 32'd0);
        chk("midreset/addr_b", 32'(addr_b), 32'd0);
        chk("midreset/mac_control", 32'(mac_control), 32'd0);
        chk("midreset/mac_data_a", 32'(mac_data_a), 32'd0);
        chk("midreset/mac_data_b", 32'(mac_data_b), 32'd0);
        chk("midreset/result", 32'(result), 32'd0);
        chk("midreset/result_valid", 32'(result_valid), 32'd0);
        chk("midreset/busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("postreset/result_valid", 32'(result_valid), 32'd0);
            chk("postreset/busy", 32'(busy), 32'd0);
        end
        run_job(vecs[0], 0, "rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
